wfg_interconnect_xbar: RTL
==========================

Name: wfg_interconnect_xbar

Overview:
Parametrised AXI-stream crossbar connecting NUM_STIMULI stimulus sources to NUM_DRIVERS driver sinks. Each driver picks one source through a select field. One source can fan out to several drivers in lock-step. Each driver output has a one-entry register slice, and select changes can be deferred to the pattern sync pulse. Sits between the stimulus cores and the driver cores, configured by its own wishbone register block.

Parameters:
NUM_STIMULI, 4, number of stimulus inputs (>=1)
NUM_DRIVERS, 4, number of driver outputs (>=1)
AXIS_DATA_WIDTH, 32, tdata width per stream
SELW, $clog2(NUM_STIMULI+1), width of each driver select field (derived; one extra code for "disconnected")

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  reset, synchronous, active-high
ctrl_en_q_i  in  1  global enable
ctrl_sync_mode_q_i  in  1  0: select applied immediately; 1: select applied on wfg_pat_sync_i
wfg_pat_sync_i  in  1  pattern sync pulse
driver_select_q_i  in  NUM_DRIVERS*SELW  requested source per driver; field d at [d*SELW +: SELW]
stimulus_tvalid_i  in  NUM_STIMULI  stimulus valid
stimulus_tdata_i  in  NUM_STIMULI*AXIS_DATA_WIDTH  stimulus data
stimulus_tready_o  out  NUM_STIMULI  stimulus ready
driver_tvalid_o  out  NUM_DRIVERS  driver valid (registered)
driver_tdata_o  out  NUM_DRIVERS*AXIS_DATA_WIDTH  driver data (registered)
driver_tready_i  in  NUM_DRIVERS  driver ready
active_select_o  out  NUM_DRIVERS*SELW  select currently in force
sel_pending_o  out  1  requested select differs from active select

Behaviour:
- Reset: active_select_o=0 (all drivers on stimulus 0); driver_tvalid_o=0; driver_tdata_o=0; all slots empty.
- Select commit:
  - Mode 0: active select <= driver_select_q_i every cycle.
  - Mode 1: load only in cycles where wfg_pat_sync_i=1; all fields load together.
  - sel_pending_o = (driver_select_q_i != active select), combinational.
- Select value >= NUM_STIMULI: driver disconnected. It never loads; its slot still drains.
- Slot d is free when !driver_tvalid_o[d] or driver_tready_i[d] (drain this cycle).
- Source s is "claimed" when at least one driver's active select equals s.
- stimulus_tready_o[s] = ctrl_en_q_i & claimed(s) & (every driver selecting s has a free slot). It is combinational from driver_tready_i and the slot state. There is no path from stimulus_tvalid_i to any ready.
- Transfer on s (tvalid & tready): every driver selecting s loads tdata[s] and sets valid, in the same cycle.
- Fan-out is atomic: either all selecting drivers receive the beat, or none do.
- Latency 1 cycle, stimulus to driver. Full throughput of 1 beat/cycle per source with a continuously ready sink.
- Drain without reload: valid clears and data holds its last value.
- Unclaimed source, or ctrl_en_q_i=0: tready=0, beats are held, never dropped.
- ctrl_en_q_i=0: no new loads; occupied slots still drain normally.
- Select change while a slot is occupied: the stored beat is delivered unchanged; the new source is used from the next load.
- A commit and a load in the same cycle use the pre-commit select (the registered value).
- wb_rst_i mid-transfer: slots are cleared and beats in flight are discarded.
- Active select comes from a registered value, so combinational paths remain acyclic.

Test Plan:
- Reset, en=1, mode 0, selects {0,1,2,3}, each stim s streams s*16+k with all tready=1 -> each driver d outputs d*16+k one cycle later, 1 beat/cycle, stimulus_tready=4'b1111.
- Fan-out: selects {2,2,2,3}; driver_tready_i[1] low 3 cycles -> stimulus_tready_o[2]=0 during the stall, and no driver 0/1/2 receives a beat the others miss; drivers 0-2 see identical sequences.
- Mode 1: change the select of driver 0 from 0 to 1 -> sel_pending_o=1 and active_select unchanged until a wfg_pat_sync_i pulse; the cycle after the pulse, active=1 and pending=0.
- Disconnect: driver 3 select=7 (NUM_STIMULI=4) -> its held beat drains, then driver_tvalid_o[3] stays 0; stimulus 3 tready=0 with stimulus_tvalid_i[3]=1.
- Enable low: en=0 with all slots full, driver_tready_i=1 -> slots drain in 1 cycle, and all stimulus_tready_o stay 0 until en=1.
- Mid-stream reset: assert wb_rst_i for 1 cycle with slots full -> the next cycle shows driver_tvalid_o=0, tdata=0, active_select_o=0.

Source files
------------

// File: rtl/wfg_interconnect_xbar.sv
// ----------------------------------------------------------------------------
// wfg_interconnect_xbar
//
// AXI-stream crossbar between the stimulus cores and the driver cores. Each
// driver picks one stimulus source through its select field; a source may
// feed several drivers at once, in which case the beat is handed to all of
// them in the same cycle or to none of them. Every driver output is a
// one-entry register slice. Select changes apply every cycle, or only on the
// pattern sync pulse when sync mode is on.
//
// Ports:
//   wb_clk_i             clock
//   wb_rst_i             synchronous active-high reset
//   ctrl_en_q_i          global enable (gates new loads only)
//   ctrl_sync_mode_q_i   0: select applied every cycle, 1: only on sync pulse
//   wfg_pat_sync_i       pattern sync pulse
//   driver_select_q_i    requested source per driver, field d at [d*SELW +: SELW]
//   stimulus_tvalid_i    stimulus valid, one bit per source
//   stimulus_tdata_i     stimulus data, source s at [s*W +: W]
//   stimulus_tready_o    stimulus ready, one bit per source
//   driver_tvalid_o      registered driver valid
//   driver_tdata_o       registered driver data
//   driver_tready_i      driver ready
//   active_select_o      select currently in force
//   sel_pending_o        requested select differs from the one in force
// ----------------------------------------------------------------------------
module wfg_interconnect_xbar #(
    parameter int NUM_STIMULI     = 4,
    parameter int NUM_DRIVERS     = 4,
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int SELW            = $clog2(NUM_STIMULI + 1)
) (
    input  logic                                   wb_clk_i,
    input  logic                                   wb_rst_i,
    input  logic                                   ctrl_en_q_i,
    input  logic                                   ctrl_sync_mode_q_i,
    input  logic                                   wfg_pat_sync_i,
    input  logic [NUM_DRIVERS*SELW-1:0]            driver_select_q_i,
    input  logic [NUM_STIMULI-1:0]                 stimulus_tvalid_i,
    input  logic [NUM_STIMULI*AXIS_DATA_WIDTH-1:0] stimulus_tdata_i,
    output logic [NUM_STIMULI-1:0]                 stimulus_tready_o,
    output logic [NUM_DRIVERS-1:0]                 driver_tvalid_o,
    output logic [NUM_DRIVERS*AXIS_DATA_WIDTH-1:0] driver_tdata_o,
    input  logic [NUM_DRIVERS-1:0]                 driver_tready_i,
    output logic [NUM_DRIVERS*SELW-1:0]            active_select_o,
    output logic                                   sel_pending_o
);

    localparam int W = AXIS_DATA_WIDTH;

    logic [NUM_DRIVERS*SELW-1:0] active_sel_q;
    logic [NUM_DRIVERS-1:0]      drv_valid_q;
    logic [NUM_DRIVERS*W-1:0]    drv_data_q;

    logic [NUM_DRIVERS-1:0]      slot_free;
    logic [NUM_STIMULI-1:0]      src_claimed;
    logic [NUM_STIMULI-1:0]      src_blocked;
    logic [NUM_STIMULI-1:0]      src_ready;
    logic [NUM_STIMULI-1:0]      src_xfer;
    logic [NUM_DRIVERS-1:0]      drv_load;
    logic [NUM_DRIVERS*W-1:0]    drv_load_data;
    logic                        commit;

    // A slot is free if empty or being drained this cycle. A source is ready
    // only if every driver listening to it can take the beat, which makes the
    // fan-out all-or-nothing. Select codes >= NUM_STIMULI match no source, so
    // a disconnected driver never loads and claims nothing.
    always_comb begin
        slot_free   = ~drv_valid_q | driver_tready_i;
        src_claimed = '0;
        src_blocked = '0;
        for (int d = 0; d < NUM_DRIVERS; d++) begin
            for (int s = 0; s < NUM_STIMULI; s++) begin
                if (active_sel_q[d*SELW +: SELW] == SELW'(s)) begin
                    src_claimed[s] = 1'b1;
                    if (!slot_free[d]) begin
                        src_blocked[s] = 1'b1;
                    end
                end
            end
        end
        src_ready = {NUM_STIMULI{ctrl_en_q_i}} & src_claimed & ~src_blocked;
        src_xfer  = src_ready & stimulus_tvalid_i;
    end

    // Loads follow the registered select, so a same-cycle commit only affects
    // the next beat.
    always_comb begin
        drv_load      = '0;
        drv_load_data = '0;
        for (int d = 0; d < NUM_DRIVERS; d++) begin
            for (int s = 0; s < NUM_STIMULI; s++) begin
                if (active_sel_q[d*SELW +: SELW] == SELW'(s)) begin
                    drv_load[d]               = src_xfer[s];
                    drv_load_data[d*W +: W]   = stimulus_tdata_i[s*W +: W];
                end
            end
        end
    end

    assign commit = !ctrl_sync_mode_q_i || wfg_pat_sync_i;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            active_sel_q <= '0;
            drv_valid_q  <= '0;
            drv_data_q   <= '0;
        end else begin
            if (commit) begin
                active_sel_q <= driver_select_q_i;
            end
            for (int d = 0; d < NUM_DRIVERS; d++) begin
                if (drv_load[d]) begin
                    drv_valid_q[d]       <= 1'b1;
                    drv_data_q[d*W +: W] <= drv_load_data[d*W +: W];
                end else if (driver_tready_i[d]) begin
                    // Data is left as-is on drain; only valid drops.
                    drv_valid_q[d] <= 1'b0;
                end
            end
        end
    end

    assign stimulus_tready_o = src_ready;
    assign driver_tvalid_o   = drv_valid_q;
    assign driver_tdata_o    = drv_data_q;
    assign active_select_o   = active_sel_q;
    assign sel_pending_o     = (driver_select_q_i != active_sel_q);

endmodule
